mk8_program_loader: RTL and testbench

Byte-stream boot loader sitting directly upstream of the Mk8 Observer CPU program memory (4096 x 32, single-port on-chip RAM). Receives a framed program image over a ready/valid byte interface from the host link and assembles little-endian 32-bit words. Writes them sequentially into the program memory's Avalon slave port. Holds the CPU in reset until a frame with a valid checksum has been written.

---
 rtl/mk8_program_loader_if.sv | 36 +++
 rtl/mk8_program_loader.sv | 205 ++++++++++++++++++++
 tb/tb_mk8_program_loader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mk8_program_loader_if.sv
// Byte-stream and program-memory bus bundle for the Mk8 program loader.
// The loader side uses "master" because it masters the memory port; the host and memory side use "slave".
interface mk8_program_loader_if #(
  parameter int ADDR_W = 12
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_writedata;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;

  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_address,
    output mem_writedata,
    output mem_byteenable,
    output mem_chipselect,
    output mem_write
  );

  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_address,
    input  mem_writedata,
    input  mem_byteenable,
    input  mem_chipselect,
    input  mem_write
  );
endinterface

// File: rtl/mk8_program_loader.sv
// Framed boot loader: A5, LEN_LO, LEN_HI, LEN*4 data bytes, CSUM -> sequential word writes.
// Holds the CPU in reset until a frame with a valid checksum has been fully written.
module mk8_program_loader #(
  parameter int DEPTH_WORDS    = 4096,
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  mk8_program_loader_if.master bus,
  output logic                 cpu_hold,
  output logic                 load_done,
  output logic                 load_error,
  output logic [1:0]           error_code
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state_r;
  logic [7:0]        len_lo_r;
  logic [15:0]       len_r;
  logic [15:0]       word_idx_r;
  logic [1:0]        byte_cnt_r;
  logic [23:0]       asm_r;
  logic [7:0]        csum_r;
  logic [TMO_W-1:0]  tmo_r;
  logic [1:0]        pend_code_r;
  logic [ADDR_W-1:0] mem_address_r;
  logic [31:0]       mem_writedata_r;
  logic              mem_write_r;
  logic              cpu_hold_r;
  logic              load_done_r;
  logic              load_error_r;
  logic [1:0]        error_code_r;

  logic              ready_s;
  logic              accept_s;
  logic              timeout_hit_s;
  logic [7:0]        csum_next_s;
  logic [15:0]       len_s;

  // Ready decode from the state register, forced low while reset is asserted
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: ready_s = ~reset;
      default:                                    ready_s = 1'b0;
    endcase
  end

  assign accept_s      = bus.in_valid & ready_s;
  assign timeout_hit_s = (tmo_r == TMO_W'(TIMEOUT_CYCLES - 1));
  assign csum_next_s   = csum_r + bus.in_data;
  assign len_s         = {bus.in_data, len_lo_r};

  assign bus.in_ready       = ready_s;
  assign bus.mem_address    = mem_address_r;
  assign bus.mem_writedata  = mem_writedata_r;
  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_chipselect = mem_write_r;
  assign bus.mem_write      = mem_write_r;
  assign cpu_hold           = cpu_hold_r;
  assign load_done          = load_done_r;
  assign load_error         = load_error_r;
  assign error_code         = error_code_r;

  // Frame parser, word assembler, write strobe and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= S_IDLE;
      len_lo_r        <= 8'h00;
      len_r           <= 16'h0000;
      word_idx_r      <= 16'h0000;
      byte_cnt_r      <= 2'd0;
      asm_r           <= 24'h000000;
      csum_r          <= 8'h00;
      tmo_r           <= {TMO_W{1'b0}};
      pend_code_r     <= 2'd0;
      mem_address_r   <= {ADDR_W{1'b0}};
      mem_writedata_r <= 32'h0000_0000;
      mem_write_r     <= 1'b0;
      cpu_hold_r      <= 1'b1;
      load_done_r     <= 1'b0;
      load_error_r    <= 1'b0;
      error_code_r    <= 2'd0;
    end else begin
      mem_write_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s && (bus.in_data == 8'hA5)) begin
            load_done_r  <= 1'b0;
            load_error_r <= 1'b0;
            error_code_r <= 2'd0;
            cpu_hold_r   <= 1'b1;
            word_idx_r   <= 16'h0000;
            byte_cnt_r   <= 2'd0;
            csum_r       <= 8'h00;
            tmo_r        <= {TMO_W{1'b0}};
            state_r      <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept_s) begin
            len_lo_r <= bus.in_data;
            csum_r   <= csum_next_s;
            tmo_r    <= {TMO_W{1'b0}};
            state_r  <= S_LEN_HI;
          end else if (timeout_hit_s) begin
            pend_code_r <= 2'd3;
            state_r     <= S_ERR;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        S_LEN_HI: begin
          if (accept_s) begin
            len_r  <= len_s;
            csum_r <= csum_next_s;
            tmo_r  <= {TMO_W{1'b0}};
            if ((len_s == 16'h0000) || (len_s > 16'(DEPTH_WORDS))) begin
              pend_code_r <= 2'd1;
              state_r     <= S_ERR;
            end else begin
              state_r <= S_DATA;
            end
          end else if (timeout_hit_s) begin
            pend_code_r <= 2'd3;
            state_r     <= S_ERR;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        S_DATA: begin
          if (accept_s) begin
            csum_r     <= csum_next_s;
            tmo_r      <= {TMO_W{1'b0}};
            byte_cnt_r <= byte_cnt_r + 2'd1;
            case (byte_cnt_r)
              2'd0:    asm_r[7:0]   <= bus.in_data;
              2'd1:    asm_r[15:8]  <= bus.in_data;
              2'd2:    asm_r[23:16] <= bus.in_data;
              default: begin
                // Fourth byte goes straight into the write word, bypassing the assembly register
                mem_address_r   <= word_idx_r[ADDR_W-1:0];
                mem_writedata_r <= {bus.in_data, asm_r};
                mem_write_r     <= 1'b1;
                state_r         <= S_WRITE;
              end
            endcase
          end else if (timeout_hit_s) begin
            pend_code_r <= 2'd3;
            state_r     <= S_ERR;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        S_WRITE: begin
          word_idx_r <= word_idx_r + 16'd1;
          tmo_r      <= {TMO_W{1'b0}};
          if ((word_idx_r + 16'd1) == len_r) begin
            state_r <= S_CSUM;
          end else begin
            state_r <= S_DATA;
          end
        end
        S_CSUM: begin
          if (accept_s) begin
            csum_r <= csum_next_s;
            tmo_r  <= {TMO_W{1'b0}};
            if (csum_next_s == 8'h00) begin
              state_r <= S_DONE;
            end else begin
              pend_code_r <= 2'd2;
              state_r     <= S_ERR;
            end
          end else if (timeout_hit_s) begin
            pend_code_r <= 2'd3;
            state_r     <= S_ERR;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        S_DONE: begin
          load_done_r <= 1'b1;
          cpu_hold_r  <= 1'b0;
          state_r     <= S_IDLE;
        end
        S_ERR: begin
          load_error_r <= 1'b1;
          error_code_r <= pend_code_r;
          cpu_hold_r   <= 1'b1;
          state_r      <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mk8_program_loader.sv
// Self-checking bench for mk8_program_loader: frame vector table, write scoreboard, corner-case sequences.
module tb_mk8_program_loader;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;
  localparam int TMO    = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_hold;
  logic       load_done;
  logic       load_error;
  logic [1:0] error_code;

  always #5 clk = ~clk;

  mk8_program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  mk8_program_loader #(
    .DEPTH_WORDS    (DEPTH),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error),
    .error_code (error_code)
  );

  int          n_cmp    = 0;
  int          n_bad    = 0;
  int          n_writes = 0;
  int          hs_waits = 0;
  logic [43:0] exp_q[$];
  logic [43:0] mon_e;
  bit          prev_write = 1'b0;

  typedef struct {
    int          len_field;
    int          nwords;
    int          csum_adj;
    logic [31:0] seed;
    logic        exp_done;
    logic [1:0]  exp_code;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe is popped against the expected address/data queue
  always @(negedge clk) begin
    if (bus.mem_write === 1'b1) begin
      n_writes++;
      check("write_single_cycle", {31'd0, prev_write}, 32'd0);
      check("write_chipselect", {31'd0, bus.mem_chipselect}, 32'd1);
      check("write_ready_low", {31'd0, bus.in_ready}, 32'd0);
      check("write_byteenable", {28'd0, bus.mem_byteenable}, 32'hF);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                 bus.mem_address, bus.mem_writedata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", {20'd0, bus.mem_address}, {20'd0, mon_e[43:32]});
        check("write_data", bus.mem_writedata, mon_e[31:0]);
      end
    end
    prev_write = (bus.mem_write === 1'b1);
  end

  // Called at posedge+1; returns at posedge+1 right after the handshake edge
  task automatic send_byte(input logic [7:0] b);
    bit hs = 1'b0;
    int k  = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!hs && k < 64) begin
      @(negedge clk);
      hs = (bus.in_ready === 1'b1);
      @(posedge clk);
      k++;
    end
    hs_waits += k;
    #1;
    if (!hs) begin
      n_cmp++;
      n_bad++;
      $display("FAIL byte_handshake: byte 0x%0h not accepted within %0d cycles", b, k);
    end
  endtask

  task automatic send_frame(input int len_field, input int nwords, input int csum_adj,
                            input logic [31:0] seed, input logic [31:0] step);
    logic [7:0]  s;
    logic [7:0]  b;
    logic [31:0] w;
    s = 8'h00;
    send_byte(8'hA5);
    b = len_field[7:0];
    s = s + b;
    send_byte(b);
    b = len_field[15:8];
    s = s + b;
    send_byte(b);
    for (int i = 0; i < nwords; i++) begin
      w = seed + 32'(i) * step;
      exp_q.push_back({12'(i), w});
      for (int j = 0; j < 4; j++) begin
        b = w[8*j +: 8];
        s = s + b;
        send_byte(b);
      end
    end
    if (nwords > 0) begin
      b = 8'h00 - s + 8'(csum_adj);
      send_byte(b);
    end
    bus.in_valid = 1'b0;
  endtask

  // Checks the cycle after the final handshake (DONE/ERR state) and the cycle after that
  task automatic check_result(input string tag, input logic exp_done, input logic [1:0] exp_code);
    @(negedge clk);
    check({tag, "_mid_done"}, {31'd0, load_done}, 32'd0);
    check({tag, "_mid_error"}, {31'd0, load_error}, 32'd0);
    check({tag, "_mid_hold"}, {31'd0, cpu_hold}, 32'd1);
    @(negedge clk);
    check({tag, "_done"}, {31'd0, load_done}, {31'd0, exp_done});
    check({tag, "_error"}, {31'd0, load_error}, {31'd0, (exp_code != 2'd0)});
    check({tag, "_code"}, {30'd0, error_code}, {30'd0, exp_code});
    check({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, ~exp_done});
    check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
    check({tag, "_write"}, {31'd0, bus.mem_write}, 32'd0);
    check({tag, "_cs"}, {31'd0, bus.mem_chipselect}, 32'd0);
    check({tag, "_addr"}, {20'd0, bus.mem_address}, 32'd0);
    check({tag, "_wdata"}, bus.mem_writedata, 32'd0);
    check({tag, "_done"}, {31'd0, load_done}, 32'd0);
    check({tag, "_error"}, {31'd0, load_error}, 32'd0);
    check({tag, "_code"}, {30'd0, error_code}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int w0;

    vecs[0] = '{1,      1, 0, 32'h12345678, 1'b1, 2'd0};
    vecs[1] = '{3,      3, 0, 32'hA5A5A5A5, 1'b1, 2'd0};
    vecs[2] = '{0,      0, 0, 32'h00000000, 1'b0, 2'd1};
    vecs[3] = '{4097,   0, 0, 32'h00000000, 1'b0, 2'd1};
    vecs[4] = '{2,      2, 1, 32'h00C0FFEE, 1'b0, 2'd2};
    vecs[5] = '{1,      1, 0, 32'hDEADBEEF, 1'b1, 2'd0};

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge clk);
    check("rst_ready_low", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_ready_low2", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("post_reset");
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].len_field, vecs[i].nwords, vecs[i].csum_adj, vecs[i].seed, 32'h01010101);
      check_result($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_code);
    end

    // Full-depth frame, in_valid held high throughout
    hs_waits = 0;
    w0       = n_writes;
    send_frame(DEPTH, DEPTH, 0, 32'h03020100, 32'h04040404);
    check("big_cycles", 32'(hs_waits), 32'(4 * DEPTH + 4 + DEPTH));
    check_result("big", 1'b1, 2'd0);
    check("big_write_count", 32'(n_writes - w0), 32'(DEPTH));

    // Reset raised while the 4th data byte is offered
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    bus.in_data = 8'h04;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_ready_low", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;

    // Source stalls after two data bytes
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    bus.in_valid = 1'b0;
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      k = c;
      if (load_error === 1'b1) break;
    end
    check("tmo_latency_in_window", {31'd0, (k >= TMO && k <= TMO + 2)}, 32'd1);
    check("tmo_error", {31'd0, load_error}, 32'd1);
    check("tmo_code", {30'd0, error_code}, 32'd3);
    check("tmo_hold", {31'd0, cpu_hold}, 32'd1);
    check("tmo_idle_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Garbage before the next sync is dropped and the following frame loads cleanly
    send_byte(8'h00);
    send_byte(8'h5A);
    send_byte(8'hFF);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("garbage_flags_kept", {30'd0, error_code}, 32'd3);
    @(posedge clk);
    #1;
    send_frame(2, 2, 0, 32'h0BADF00D, 32'h11111111);
    check_result("recover", 1'b1, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
